// File: rtl/tis_node_pkg.sv
// Shared definitions for the TIS-100 execution node.
// Holds the default datapath widths, the TIS value range, the next-address op
// encoding used by the decoder and the sequencer, and the sequencer state type.
// No ports: compile-time definitions only.
package tis_node_pkg;

  localparam int DEFAULT_AW  = 8;
  localparam int DEFAULT_DW  = 11;
  localparam int DEFAULT_SCW = 8;

  localparam int TIS_MAX = 999;
  localparam int TIS_MIN = -999;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JEZ  = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_JGZ  = 3'd4;
  localparam logic [2:0] OP_JLZ  = 3'd5;
  localparam logic [2:0] OP_JRO  = 3'd6;
  localparam logic [2:0] OP_HOLD = 3'd7;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STALLED = 1'b1
  } seq_state_e;

endpackage

// File: rtl/ip_sequencer_if.sv
// Bundle between the decoder/ALU side (master) and the instruction-pointer
// sequencer (slave).
// Master drives: stall, op, acc, jaddr, joff, prog_last.
// Slave drives : addr_instr, taken, wrapped, bad_target, stall_cnt.
interface ip_sequencer_if
  import tis_node_pkg::*;
#(
  parameter int AW  = DEFAULT_AW,
  parameter int DW  = DEFAULT_DW,
  parameter int SCW = DEFAULT_SCW
);

  logic                 stall;
  logic [2:0]           op;
  logic signed [DW-1:0] acc;
  logic [AW-1:0]        jaddr;
  logic signed [DW-1:0] joff;
  logic [AW-1:0]        prog_last;

  logic [AW-1:0]        addr_instr;
  logic                 taken;
  logic                 wrapped;
  logic                 bad_target;
  logic [SCW-1:0]       stall_cnt;

  modport master (
    output stall, op, acc, jaddr, joff, prog_last,
    input  addr_instr, taken, wrapped, bad_target, stall_cnt
  );

  modport slave (
    input  stall, op, acc, jaddr, joff, prog_last,
    output addr_instr, taken, wrapped, bad_target, stall_cnt
  );

endinterface

// File: rtl/ip_jro_clamp.sv
// Relative-jump target computation: pc + joff, clamped to [0, prog_last].
// Ports: pc (current address), joff (signed offset), prog_last (last valid
// index), target (clamped address). Purely combinational.
module ip_jro_clamp #(
  parameter int AW = 8,
  parameter int DW = 11
) (
  input  logic [AW-1:0]        pc,
  input  logic signed [DW-1:0] joff,
  input  logic [AW-1:0]        prog_last,
  output logic [AW-1:0]        target
);

  localparam int SW = DW + 2;

  logic signed [SW-1:0] pc_ext;
  logic signed [SW-1:0] off_ext;
  logic signed [SW-1:0] last_ext;
  logic signed [SW-1:0] sum;

  // The pc is an unsigned address, so it is widened with zeros; two extra
  // bits keep the sum from overflowing for any pc/offset combination.
  always_comb begin
    pc_ext   = signed'({{(SW-AW){1'b0}}, pc});
    last_ext = signed'({{(SW-AW){1'b0}}, prog_last});
    off_ext  = {{2{joff[DW-1]}}, joff};
    sum      = pc_ext + off_ext;
    if (sum < 0) begin
      target = '0;
    end else if (sum > last_ext) begin
      target = prog_last;
    end else begin
      target = sum[AW-1:0];
    end
  end

endmodule

// File: rtl/ip_sequencer.sv
// Instruction-pointer sequencer for a TIS-100 execution node.
// Holds the current instruction address and computes the next one every
// cycle: sequential advance with wrap, absolute/conditional jumps with a
// program-range check, clamped relative jumps, hold, and stall with a
// saturating stall counter.
// Ports: clk, rst (synchronous, active high), bus (ip_sequencer_if.slave).
module ip_sequencer
  import tis_node_pkg::*;
#(
  parameter int AW  = DEFAULT_AW,
  parameter int DW  = DEFAULT_DW,
  parameter int SCW = DEFAULT_SCW
) (
  input logic           clk,
  input logic           rst,
  ip_sequencer_if.slave bus
);

  seq_state_e     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           taken_q, taken_d;
  logic           wrapped_q, wrapped_d;
  logic           bad_q, bad_d;
  logic [SCW-1:0] cnt_q, cnt_d;

  logic [AW-1:0]  jro_addr;
  logic [AW:0]    pc_plus1;
  logic           acc_zero;
  logic           acc_neg;
  logic           do_jump;
  logic           do_seq;

  ip_jro_clamp #(.AW(AW), .DW(DW)) u_jro_clamp (
    .pc        (addr_q),
    .joff      (bus.joff),
    .prog_last (bus.prog_last),
    .target    (jro_addr)
  );

  // Next-state selection. A stall freezes the address and clears the
  // redirect flags; otherwise op picks between sequential advance, an
  // absolute jump, the clamped relative jump or hold.
  always_comb begin
    state_d   = ST_RUN;
    addr_d    = addr_q;
    taken_d   = 1'b0;
    wrapped_d = 1'b0;
    bad_d     = 1'b0;
    cnt_d     = '0;
    do_jump   = 1'b0;
    do_seq    = 1'b0;
    acc_zero  = (bus.acc == '0);
    acc_neg   = bus.acc[DW-1];
    pc_plus1  = {1'b0, addr_q} + 1'b1;

    if (bus.stall) begin
      state_d = ST_STALLED;
      // Entering a stall always starts the count at one.
      if (state_q == ST_STALLED) begin
        cnt_d = (cnt_q == {SCW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = {{(SCW-1){1'b0}}, 1'b1};
      end
    end else begin
      case (bus.op)
        OP_NEXT: do_seq = 1'b1;
        OP_JMP:  do_jump = 1'b1;
        OP_JEZ:  begin do_jump = acc_zero;              do_seq = !acc_zero; end
        OP_JNZ:  begin do_jump = !acc_zero;             do_seq = acc_zero; end
        OP_JGZ:  begin do_jump = !acc_zero && !acc_neg; do_seq = acc_zero || acc_neg; end
        OP_JLZ:  begin do_jump = acc_neg;               do_seq = !acc_neg; end
        OP_JRO:  begin
          addr_d  = jro_addr;
          // A relative jump that lands on pc+1 is indistinguishable from
          // sequential flow, so it does not count as a redirect.
          taken_d = ({1'b0, jro_addr} != pc_plus1);
        end
        default: ;
      endcase

      if (do_jump) begin
        taken_d = 1'b1;
        if (bus.jaddr > bus.prog_last) begin
          addr_d = '0;
          bad_d  = 1'b1;
        end else begin
          addr_d = bus.jaddr;
        end
      end else if (do_seq) begin
        // ">=" also recovers a pc left beyond a shrunken program.
        if (addr_q >= bus.prog_last) begin
          addr_d    = '0;
          wrapped_d = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
    end
  end

  // Single register process for the state and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      addr_q    <= '0;
      taken_q   <= 1'b0;
      wrapped_q <= 1'b0;
      bad_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      taken_q   <= taken_d;
      wrapped_q <= wrapped_d;
      bad_q     <= bad_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.addr_instr = addr_q;
  assign bus.taken      = taken_q;
  assign bus.wrapped    = wrapped_q;
  assign bus.bad_target = bad_q;
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_ip_sequencer.sv
// Testbench for ip_sequencer: directed steps followed by a randomized run,
// all compared against an integer-level model of the sequencing rules.
module tb_ip_sequencer;
  import tis_node_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 11;
  localparam int SCW = 8;
  localparam int CNT_MAX = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  int  m_pc = 0;
  int  m_cnt = 0;
  bit  m_taken = 0;
  bit  m_wrapped = 0;
  bit  m_bad = 0;

  ip_sequencer_if #(.AW(AW), .DW(DW), .SCW(SCW)) bus ();

  ip_sequencer #(.AW(AW), .DW(DW), .SCW(SCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".addr"},    32'(bus.addr_instr), 32'(m_pc));
    checkValue({tag, ".taken"},   32'(bus.taken),      32'(m_taken));
    checkValue({tag, ".wrapped"}, 32'(bus.wrapped),    32'(m_wrapped));
    checkValue({tag, ".bad"},     32'(bus.bad_target), 32'(m_bad));
    checkValue({tag, ".cnt"},     32'(bus.stall_cnt),  32'(m_cnt));
  endtask

  // Reference behaviour written directly from the sequencing rules.
  task automatic modelStep(input bit r, input bit st, input int op, input int acc,
                           input int jaddr, input int joff, input int pl);
    bit cond;
    int t;
    if (r) begin
      m_pc = 0; m_taken = 0; m_wrapped = 0; m_bad = 0; m_cnt = 0;
      return;
    end
    m_taken = 0; m_wrapped = 0; m_bad = 0;
    if (st) begin
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      return;
    end
    m_cnt = 0;
    case (op)
      0: cond = 0;
      1: cond = 1;
      2: cond = (acc == 0);
      3: cond = (acc != 0);
      4: cond = (acc > 0);
      5: cond = (acc < 0);
      default: cond = 0;
    endcase
    if (op == 6) begin
      t = m_pc + joff;
      if (t < 0) t = 0;
      if (t > pl) t = pl;
      m_taken = (t != m_pc + 1);
      m_pc = t;
    end else if (op == 7) begin
      m_pc = m_pc;
    end else if (cond) begin
      m_taken = 1;
      if (jaddr > pl) begin
        m_pc = 0;
        m_bad = 1;
      end else begin
        m_pc = jaddr;
      end
    end else begin
      if (m_pc >= pl) begin
        m_pc = 0;
        m_wrapped = 1;
      end else begin
        m_pc = m_pc + 1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare.
  task automatic applyStimulus(input string tag, input bit r, input bit st, input int op,
                               input int acc, input int jaddr, input int joff, input int pl);
    rst           = r;
    bus.stall     = st;
    bus.op        = 3'(op);
    bus.acc       = DW'(acc);
    bus.jaddr     = AW'(jaddr);
    bus.joff      = DW'(joff);
    bus.prog_last = AW'(pl);
    @(posedge clk);
    #1;
    modelStep(r, st, op, acc, jaddr, joff, pl);
    checkOutput(tag);
  endtask

  initial begin
    int cond_op[5]   = '{4, 4, 5, 2, 3};
    int cond_acc[5]  = '{5, 0, -1, 0, 0};
    int cond_exp[5]  = '{7, 3, 7, 7, 3};
    int jro_off[4]   = '{-999, 999, 0, 1};
    int jro_exp[4]   = '{0, 10, 5, 6};
    int jro_tkn[4]   = '{1, 1, 1, 0};
    int r_op, r_acc, r_ja, r_off, r_pl;
    bit r_st, r_rst;

    // Reset state.
    applyStimulus("reset0", 1, 0, OP_NEXT, 0, 0, 0, 14);
    applyStimulus("reset1", 1, 1, OP_JMP, 0, 5, 0, 14);
    checkValue("reset_addr", 32'(bus.addr_instr), 32'd0);
    checkValue("reset_cnt", 32'(bus.stall_cnt), 32'd0);

    // Sequential advance with wrap at prog_last=14.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus("next", 0, 0, OP_NEXT, 0, 0, 0, 14);
      checkValue("next_addr", 32'(bus.addr_instr), 32'((i <= 14) ? i : ((i == 15) ? 0 : 1)));
      checkValue("next_wrap", 32'(bus.wrapped), 32'(i == 15));
    end

    // Absolute jumps from pc=3, in range and out of range.
    applyStimulus("to3a", 0, 0, OP_NEXT, 0, 0, 0, 14);
    applyStimulus("to3b", 0, 0, OP_NEXT, 0, 0, 0, 14);
    checkValue("pc3", 32'(bus.addr_instr), 32'd3);
    applyStimulus("jmp9", 0, 0, OP_JMP, 0, 9, 0, 14);
    checkValue("jmp9_addr", 32'(bus.addr_instr), 32'd9);
    checkValue("jmp9_taken", 32'(bus.taken), 32'd1);
    applyStimulus("jmp20", 0, 0, OP_JMP, 0, 20, 0, 14);
    checkValue("jmp20_addr", 32'(bus.addr_instr), 32'd0);
    checkValue("jmp20_bad", 32'(bus.bad_target), 32'd1);

    // Conditional jumps with jaddr=7 from pc=2.
    for (int i = 0; i < 5; i++) begin
      applyStimulus("cond_setup", 0, 0, OP_JMP, 0, 2, 0, 14);
      applyStimulus("cond", 0, 0, cond_op[i], cond_acc[i], 7, 0, 14);
      checkValue("cond_addr", 32'(bus.addr_instr), 32'(cond_exp[i]));
    end

    // Relative jumps from pc=5 with prog_last=10.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("jro_setup", 0, 0, OP_JMP, 0, 5, 0, 10);
      applyStimulus("jro", 0, 0, OP_JRO, 0, 0, jro_off[i], 10);
      checkValue("jro_addr", 32'(bus.addr_instr), 32'(jro_exp[i]));
      checkValue("jro_taken", 32'(bus.taken), 32'(jro_tkn[i]));
    end

    // Long stall: counter saturates and address holds at 6.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("stall", 0, 1, OP_JMP, 0, 3, 0, 10);
    end
    checkValue("stall_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));
    checkValue("stall_hold", 32'(bus.addr_instr), 32'd6);
    applyStimulus("release", 0, 0, OP_NEXT, 0, 0, 0, 10);
    checkValue("release_addr", 32'(bus.addr_instr), 32'd7);
    checkValue("release_cnt", 32'(bus.stall_cnt), 32'd0);

    // Reset during a stall at pc=12.
    applyStimulus("to12", 0, 0, OP_JMP, 0, 12, 0, 14);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall12", 0, 1, OP_NEXT, 0, 0, 0, 14);
    end
    checkValue("stall12_cnt", 32'(bus.stall_cnt), 32'd3);
    applyStimulus("rst_stall", 1, 1, OP_JMP, 0, 4, 0, 14);
    checkValue("rst_stall_addr", 32'(bus.addr_instr), 32'd0);
    checkValue("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    applyStimulus("after_rst", 0, 0, OP_NEXT, 0, 0, 0, 14);
    checkValue("after_rst_addr", 32'(bus.addr_instr), 32'd1);

    // Randomized run; prog_last changes occasionally.
    r_pl = 20;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) r_pl = int'($urandom_range(255));
      r_rst = ($urandom_range(63) == 0);
      r_st  = ($urandom_range(4) == 0);
      r_op  = int'($urandom_range(7));
      r_acc = (($urandom_range(3) == 0) ? 0 : int'($urandom_range(2 * TIS_MAX)) + TIS_MIN);
      r_ja  = int'($urandom_range(255));
      r_off = int'($urandom_range(2 * TIS_MAX)) + TIS_MIN;
      if ($urandom_range(3) == 0) r_off = int'($urandom_range(4)) - 2;
      applyStimulus("rand", r_rst, r_st, r_op, r_acc, r_ja, r_off, r_pl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
